// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode / funct constants of the 13-instruction subset
//   - ALU control codes
//   - npc_sel, reg_dst, wd_sel and ext_op encodings
//   - FSM state enumeration (codes are visible on the debug state output)
//   - instruction class enumeration produced by mc_ctrl_dec
// Optional feature macro used elsewhere in the slice: MC_CTRL_EXC_EN.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operations
    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,
        ALU_SUBU = 4'd1,
        ALU_OR   = 4'd2,
        ALU_BB   = 4'd3,   // pass operand B
        ALU_AA   = 4'd4,   // pass operand A
        ALU_ADD  = 4'd5,   // signed add (overflow-trapping in the ALU)
        ALU_LT   = 4'd6    // signed set-less-than
    } alu_ctrl_e;

    // Next-PC source
    localparam logic [2:0] NPC_PC4    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_J      = 3'b011;
    localparam logic [2:0] NPC_RS     = 3'b100;
    localparam logic [2:0] NPC_EXC    = 3'b101;

    // Register file destination
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register file write-data source
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // FSM states; EXC is only ever entered when MC_CTRL_EXC_EN is defined
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXC    = 3'd5
    } state_e;

    // Instruction class as seen by the sequencer
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RALU    = 4'd1,   // addu, subu, slt
        CLS_JR      = 4'd2,
        CLS_IMM     = 4'd3,   // ori, lui, addi, addiu
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8
    } instr_cls_e;

    // Classes whose result is written back in the WB state
    function automatic logic needs_wb(input instr_cls_e cls);
        return (cls == CLS_RALU) || (cls == CLS_IMM) || (cls == CLS_LW);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_if
// Bundle between the multi-cycle controller and its datapath/memories.
//   master : the controller (consumes IR fields, zero and ready flags;
//            drives strobes, selects and debug outputs)
//   slave  : the datapath side (the opposite directions)
// Optional macro: MC_CTRL_EXC_EN adds the epc_write strobe.
//
// Handshake: both memories use a ready-only handshake. The request is
// implicit in FETCH for instruction memory and is mem_read/mem_write for
// data memory; the request is held unchanged every cycle until the
// responder raises imem_ready/dmem_ready, and the transfer completes at the
// clock edge that samples ready=1. A wait timeout may withdraw a request
// in the cycle it fires, unless ready is high in that same cycle.
// ---------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] npc_sel;
    logic [1:0] ext_op;
    logic [3:0] alu_ctrl;
    logic [2:0] state;
    logic       illegal;
    logic       bus_err;
`ifdef MC_CTRL_EXC_EN
    logic       epc_write;
`endif

`ifdef MC_CTRL_EXC_EN
    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
               reg_dst, wd_sel, npc_sel, ext_op, alu_ctrl, state,
               illegal, bus_err, epc_write
    );
    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
               reg_dst, wd_sel, npc_sel, ext_op, alu_ctrl, state,
               illegal, bus_err, epc_write
    );
`else
    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
               reg_dst, wd_sel, npc_sel, ext_op, alu_ctrl, state,
               illegal, bus_err
    );
    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
               reg_dst, wd_sel, npc_sel, ext_op, alu_ctrl, state,
               illegal, bus_err
    );
`endif
endinterface

// File: rtl/mc_ctrl_dec.sv
// ---------------------------------------------------------------------------
// mc_ctrl_dec
// Purely combinational instruction decode shared by the sequencer.
//   opcode, funct : IR fields
//   cls           : instruction class (CLS_ILLEGAL for anything undecodable)
//   alu_ctrl      : ALU operation used in EXEC
//   ext_op        : immediate extension used in EXEC
//   alu_src       : 1 selects the extended immediate as ALU operand B
// ---------------------------------------------------------------------------
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_cls_e cls,
    output alu_ctrl_e  alu_ctrl,
    output logic [1:0] ext_op,
    output logic       alu_src
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_ctrl = ALU_ADDU;
        ext_op   = EXT_ZERO;
        alu_src  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin cls = CLS_RALU; alu_ctrl = ALU_ADDU; end
                    FN_SUBU: begin cls = CLS_RALU; alu_ctrl = ALU_SUBU; end
                    FN_SLT:  begin cls = CLS_RALU; alu_ctrl = ALU_LT;   end
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls = CLS_IMM; alu_ctrl = ALU_OR;   ext_op = EXT_ZERO; alu_src = 1'b1;
            end
            OP_LUI: begin
                // The extender already places imm in the upper half; ALU passes B.
                cls = CLS_IMM; alu_ctrl = ALU_BB;   ext_op = EXT_LUI;  alu_src = 1'b1;
            end
            OP_ADDI: begin
                cls = CLS_IMM; alu_ctrl = ALU_ADD;  ext_op = EXT_SIGN; alu_src = 1'b1;
            end
            OP_ADDIU: begin
                cls = CLS_IMM; alu_ctrl = ALU_ADDU; ext_op = EXT_SIGN; alu_src = 1'b1;
            end
            OP_LW: begin
                cls = CLS_LW;  alu_ctrl = ALU_ADDU; ext_op = EXT_SIGN; alu_src = 1'b1;
            end
            OP_SW: begin
                cls = CLS_SW;  alu_ctrl = ALU_ADDU; ext_op = EXT_SIGN; alu_src = 1'b1;
            end
            OP_BEQ: begin
                // Compare by subtraction; the zero flag decides the branch.
                cls = CLS_BEQ; alu_ctrl = ALU_SUBU; ext_op = EXT_SIGN; alu_src = 1'b0;
            end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle MIPS control unit: sequences each instruction through
// FETCH / DECODE / EXEC / MEM / WB and drives the shared-ALU,
// single-memory-port datapath.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mc_ctrl_if.master -- IR fields, zero flag, memory ready
//              flags in; strobes, selects, debug state, illegal and
//              bus_err pulses out
// Parameters:
//   WAIT_W      : width of the saturating memory wait counter
//   MEM_TIMEOUT : wait cycles tolerated in FETCH or MEM before aborting
//                 the instruction with bus_err; 0 disables the timeout
// Optional macro MC_CTRL_EXC_EN: illegal instructions enter EXC, which
// loads the exception vector and raises epc_write for one cycle. Without
// it, illegal instructions are skipped like a NOP.
// ---------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;

    instr_cls_e cls;
    alu_ctrl_e  dec_alu_ctrl;
    logic [1:0] dec_ext_op;
    logic       dec_alu_src;

    logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src;
    logic [1:0] reg_dst, wd_sel, ext_op;
    logic [2:0] npc_sel;
    alu_ctrl_e  alu_ctrl;
    logic       illegal, bus_err, epc_write;
    logic       timeout_hit;
    logic [WAIT_W-1:0] wait_inc;

    mc_ctrl_dec u_dec (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .cls      (cls),
        .alu_ctrl (dec_alu_ctrl),
        .ext_op   (dec_ext_op),
        .alu_src  (dec_alu_src)
    );

    // Counter never wraps, so a long stall cannot alias back below the limit.
    assign wait_inc    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (int'(wait_q) >= MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;         // cleared on every state change or abort
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALU;
        npc_sel   = NPC_PC4;
        ext_op    = EXT_ZERO;
        alu_ctrl  = ALU_ADDU;
        illegal   = 1'b0;
        bus_err   = 1'b0;
        epc_write = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    // Load IR and advance PC to PC+4 on the same edge.
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    npc_sel  = NPC_PC4;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err  = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    wait_d   = wait_inc;
                end
            end

            S_DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    illegal = 1'b1;
`ifdef MC_CTRL_EXC_EN
                    state_d = S_EXC;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_src  = dec_alu_src;
                ext_op   = dec_ext_op;
                alu_ctrl = dec_alu_ctrl;
                case (cls)
                    CLS_RALU, CLS_IMM: state_d = S_WB;
                    CLS_LW, CLS_SW:    state_d = S_MEM;
                    CLS_BEQ: begin
                        pc_write = bus.zero;
                        npc_sel  = NPC_BRANCH;
                        state_d  = S_FETCH;
                    end
                    CLS_J: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_J;
                        state_d  = S_FETCH;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_RS;
                        state_d  = S_FETCH;
                    end
                    CLS_JAL: begin
                        // PC still holds PC+4 here, so the link value is ready.
                        pc_write  = 1'b1;
                        npc_sel   = NPC_JAL;
                        reg_write = 1'b1;
                        reg_dst   = RD_RA;
                        wd_sel    = WD_PC4;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                if (bus.dmem_ready) begin
                    // Ready beats a same-cycle timeout.
                    mem_read  = (cls == CLS_LW);
                    mem_write = (cls == CLS_SW);
                    state_d   = needs_wb(cls) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    bus_err   = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    mem_read  = (cls == CLS_LW);
                    mem_write = (cls == CLS_SW);
                    wait_d    = wait_inc;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (cls == CLS_RALU) ? RD_RD : RD_RT;
                wd_sel    = (cls == CLS_LW) ? WD_MDR : WD_ALU;
                state_d   = S_FETCH;
            end

`ifdef MC_CTRL_EXC_EN
            S_EXC: begin
                pc_write  = 1'b1;
                npc_sel   = NPC_EXC;
                epc_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif

            default: state_d = S_FETCH;
        endcase

        // An instruction caught by reset must not write anything.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            alu_src   = 1'b0;
            reg_dst   = RD_RT;
            wd_sel    = WD_ALU;
            npc_sel   = NPC_PC4;
            ext_op    = EXT_ZERO;
            alu_ctrl  = ALU_ADDU;
            illegal   = 1'b0;
            bus_err   = 1'b0;
            epc_write = 1'b0;
        end
    end

    assign bus.pc_write  = pc_write;
    assign bus.ir_write  = ir_write;
    assign bus.reg_write = reg_write;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.alu_src   = alu_src;
    assign bus.reg_dst   = reg_dst;
    assign bus.wd_sel    = wd_sel;
    assign bus.npc_sel   = npc_sel;
    assign bus.ext_op    = ext_op;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.state     = state_q;
    assign bus.illegal   = illegal;
    assign bus.bus_err   = bus_err;
`ifdef MC_CTRL_EXC_EN
    assign bus.epc_write = epc_write;
`else
    logic unused_epc;
    assign unused_epc = epc_write;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl
// Directed bench for mc_ctrl. u_dut uses the default parameters (timeout
// off); u_dut_to uses MEM_TIMEOUT=4. Each cycle's control word is packed as
// {state[2:0], pc_write, ir_write, reg_write, mem_read, mem_write,
//  reg_dst[1:0], wd_sel[1:0], npc_sel[2:0], illegal, bus_err}.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mc_ctrl_if a ();
    mc_ctrl_if b ();

    mc_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a.master)
    );

    mc_ctrl #(.WAIT_W(8), .MEM_TIMEOUT(4)) u_dut_to (
        .clk (clk),
        .rst (rst),
        .bus (b.master)
    );

    // {pc_write, ir_write, reg_write, mem_read, mem_write}
    function automatic logic [16:0] es(input logic [2:0] st, input logic [4:0] strb,
                                       input logic [1:0] rd, input logic [1:0] wd,
                                       input logic [2:0] npc, input logic ill,
                                       input logic be);
        return {st, strb, rd, wd, npc, ill, be};
    endfunction

    function automatic logic [16:0] obs_a();
        return {a.state, a.pc_write, a.ir_write, a.reg_write, a.mem_read, a.mem_write,
                a.reg_dst, a.wd_sel, a.npc_sel, a.illegal, a.bus_err};
    endfunction

    function automatic logic [16:0] obs_b();
        return {b.state, b.pc_write, b.ir_write, b.reg_write, b.mem_read, b.mem_write,
                b.reg_dst, b.wd_sel, b.npc_sel, b.illegal, b.bus_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; checks this cycle's outputs, then moves to the next cycle.
    task automatic cyc_a(input string tag, input logic [16:0] e);
        #1;
        chk(tag, 32'(obs_a()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string tag, input logic [16:0] e);
        #1;
        chk(tag, 32'(obs_b()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // {alu_src, ext_op, alu_ctrl}
    task automatic chk_alu(input string tag, input logic src, input logic [1:0] ext,
                           input logic [3:0] alu);
        #1;
        chk(tag, 32'({a.alu_src, a.ext_op, a.alu_ctrl}), 32'({src, ext, alu}));
    endtask

    // R-type ALU or immediate instruction: F, D, E, WB (4 cycles)
    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic src, input logic [1:0] ext, input logic [3:0] alu,
                           input logic [1:0] rd);
        a.opcode = op; a.funct = fn; a.imem_ready = 1'b1;
        cyc_a({tag, "_f"}, es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a({tag, "_d"}, es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        chk_alu({tag, "_alu"}, src, ext, alu);
        cyc_a({tag, "_e"}, es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a({tag, "_w"}, es(3'd4, 5'b00100, rd,    2'b00, 3'b000, 1'b0, 1'b0));
    endtask

    // Control-flow instruction: F, D, E (3 cycles); e is the EXEC word
    task automatic run_cf(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic [16:0] e);
        a.opcode = op; a.funct = fn; a.zero = z; a.imem_ready = 1'b1;
        cyc_a({tag, "_f"}, es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a({tag, "_d"}, es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a({tag, "_e"}, e);
    endtask

    initial begin
        rst = 1'b1;
        a.opcode = 6'd0; a.funct = 6'd0; a.zero = 1'b0; a.imem_ready = 1'b0; a.dmem_ready = 1'b0;
        b.opcode = 6'd0; b.funct = 6'd0; b.zero = 1'b0; b.imem_ready = 1'b0; b.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: FETCH, and imem_ready must not produce strobes
        a.imem_ready = 1'b1;
        b.imem_ready = 1'b1;
        #1;
        chk("rst_a", 32'(obs_a()), 32'(es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0)));
        chk("rst_b", 32'(obs_b()), 32'(es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst = 1'b0;
        b.imem_ready = 1'b0;

        // ALU instructions: {alu_src, ext_op, alu_ctrl} and WB reg_dst
        run_alu("addu",  6'b000000, 6'b100001, 1'b0, 2'b00, 4'd0, 2'b01);
        run_alu("subu",  6'b000000, 6'b100011, 1'b0, 2'b00, 4'd1, 2'b01);
        run_alu("slt",   6'b000000, 6'b101010, 1'b0, 2'b00, 4'd6, 2'b01);
        run_alu("ori",   6'b001101, 6'b000000, 1'b1, 2'b00, 4'd2, 2'b00);
        run_alu("lui",   6'b001111, 6'b000000, 1'b1, 2'b10, 4'd3, 2'b00);
        run_alu("addi",  6'b001000, 6'b000000, 1'b1, 2'b01, 4'd5, 2'b00);
        run_alu("addiu", 6'b001001, 6'b000000, 1'b1, 2'b01, 4'd0, 2'b00);

        // FETCH waits for imem_ready; no timeout on this instance
        a.imem_ready = 1'b0;
        cyc_a("fhold_1", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++)
            cyc_a("fhold_n", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));

        // lw with three wait cycles: F D E M M M M W = 8 cycles
        a.opcode = 6'b100011; a.funct = 6'd0; a.imem_ready = 1'b1; a.dmem_ready = 1'b0;
        cyc_a("lw_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("lw_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        chk_alu("lw_alu", 1'b1, 2'b01, 4'd0);
        cyc_a("lw_e", es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc_a("lw_mwait", es(3'd3, 5'b00010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        a.dmem_ready = 1'b1;
        cyc_a("lw_mdone", es(3'd3, 5'b00010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("lw_w",     es(3'd4, 5'b00100, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0));

        // sw without wait: F D E M = 4 cycles, back to FETCH
        a.opcode = 6'b101011;
        cyc_a("sw_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("sw_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("sw_e", es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("sw_m", es(3'd3, 5'b00001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));

        // Control flow, 3 cycles each
        run_cf("beq_z0", 6'b000100, 6'd0, 1'b0,
               es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0));
        run_cf("beq_z1", 6'b000100, 6'd0, 1'b1,
               es(3'd2, 5'b10000, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0));
        run_cf("j",      6'b000010, 6'd0, 1'b0,
               es(3'd2, 5'b10000, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0));
        run_cf("jr",     6'b000000, 6'b001000, 1'b0,
               es(3'd2, 5'b10000, 2'b00, 2'b00, 3'b100, 1'b0, 1'b0));
        run_cf("jal",    6'b000011, 6'd0, 1'b0,
               es(3'd2, 5'b10100, 2'b10, 2'b10, 3'b010, 1'b0, 1'b0));

        // Illegal opcode, then an R-type with an unknown funct
        a.opcode = 6'b111111; a.funct = 6'd0;
        cyc_a("ill_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("ill_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
`ifdef MC_CTRL_EXC_EN
        #1;
        chk("ill_epc", 32'(a.epc_write), 32'(1));
        cyc_a("ill_exc", es(3'd5, 5'b10000, 2'b00, 2'b00, 3'b101, 1'b0, 1'b0));
`endif
        a.opcode = 6'b000000; a.funct = 6'b000000;
        cyc_a("illfn_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("illfn_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
`ifdef MC_CTRL_EXC_EN
        cyc_a("illfn_exc", es(3'd5, 5'b10000, 2'b00, 2'b00, 3'b101, 1'b0, 1'b0));
`endif

        // Reset in the middle of a lw memory wait
        a.opcode = 6'b100011; a.dmem_ready = 1'b0;
        cyc_a("rlw_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("rlw_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("rlw_e", es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("rlw_m", es(3'd3, 5'b00010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        rst = 1'b1;
        cyc_a("rlw_rst_m", es(3'd3, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_a("rlw_rst_f", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        rst = 1'b0;
        cyc_a("rlw_after", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));

        // Timeout instance: restart cleanly, then FETCH timeout
        rst = 1'b1;
        b.imem_ready = 1'b0; b.dmem_ready = 1'b0; b.opcode = 6'b101011;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc_b("fto_wait", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("fto_fire",  es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1));
        cyc_b("fto_clear", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));

        // sw with dmem_ready stuck low: bus_err on the 5th MEM cycle
        b.imem_ready = 1'b1;
        cyc_b("sto_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("sto_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("sto_e", es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            cyc_b("sto_mwait", es(3'd3, 5'b00001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("sto_fire", es(3'd3, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1));

        // Same again, but ready arrives in the timeout cycle and wins
        cyc_b("srw_f", es(3'd0, 5'b11000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("srw_d", es(3'd1, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc_b("srw_e", es(3'd2, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            cyc_b("srw_mwait", es(3'd3, 5'b00001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        b.dmem_ready = 1'b1;
        cyc_b("srw_win",  es(3'd3, 5'b00001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        b.imem_ready = 1'b0; b.dmem_ready = 1'b0;
        cyc_b("srw_next", es(3'd0, 5'b00000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Decodes the same 13-instruction subset: addu, subu, slt, jr, ori, lui, lw, sw, addi, addiu, beq, j, jal.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, with ready handshakes on instruction and data memory and an optional wait-timeout counter.
- Drives the shared-ALU, single-memory-port multi-cycle datapath.

Parameters:
- WAIT_W, 8: width of the memory wait counter.
- MEM_TIMEOUT, 0: maximum wait cycles in FETCH or MEM before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- reg_write  out  1  register file write strobe
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- alu_src  out  1  0 = rt, 1 = extended immediate
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU out, 01 MDR, 10 PC+4
- npc_sel  out  3  000 PC+4, 001 branch, 010/011 jump target (jal/j), 100 rs, 101 exception vector
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 shift left 16
- alu_ctrl  out  4  ALU operation
- state  out  3  current state code, for debug
- illegal  out  1  one-cycle pulse on an undecodable instruction
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (rst=1 at a clk edge): state goes to FETCH, wait counter clears, and all strobes and selects are 0. Reset mid-instruction abandons the instruction without any write. While rst=1 all strobes are forced 0.
- Outputs are Moore-decoded from state and the IR fields. The only Mealy terms are imem_ready, dmem_ready and zero gating the strobes listed below.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5.
- FETCH:
  - Holds until imem_ready=1.
  - In the imem_ready cycle: ir_write=1, pc_write=1, npc_sel=000, then go to DECODE.
- DECODE:
  - Legal instruction: go to EXEC.
  - Illegal instruction: pulse illegal=1 and go to FETCH (no EXC_EN) or EXC (EXC_EN).
- EXEC:
  - alu_src, ext_op and alu_ctrl follow the single-cycle encoding.
  - R-type ALU ops and ori/lui/addi/addiu go to WB.
  - lw/sw go to MEM.
  - beq: pc_write=zero, npc_sel=001, then FETCH.
  - j: pc_write=1, npc_sel=011, then FETCH.
  - jr: pc_write=1, npc_sel=100, then FETCH.
  - jal: pc_write=1, npc_sel=010, reg_write=1, reg_dst=10, wd_sel=10, then FETCH.
- MEM:
  - mem_read (lw) or mem_write (sw) is held high until dmem_ready=1.
  - lw then goes to WB; sw goes to FETCH.
- WB:
  - reg_write=1, then FETCH.
  - reg_dst=01 for R-type, 00 otherwise.
  - wd_sel=01 for lw, 00 otherwise.
- Latency in cycles, with zero memory wait: R-type/imm = 4, lw = 5, sw = 4, beq/j/jr/jal = 3.
- Wait counter:
  - Increments each FETCH or MEM cycle with ready=0 and clears on any state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT: pulse bus_err, deassert requests, go to FETCH with no writes.
  - If ready arrives in the same cycle as the timeout, ready wins.
  - The counter saturates at 2^WAIT_W−1 and never wraps.
- alu_ctrl codes: Addu=0, Subu=1, Or=2, Bb=3, Aa=4, Add=5, Lt=6. Outside EXEC, alu_ctrl=Addu.

Optional Feature:
- Macro: MC_CTRL_EXC_EN.
- Defined: illegal instructions enter EXC, which for one cycle drives pc_write=1, npc_sel=101 and an extra output port epc_write=1, then goes to FETCH.
- Undefined: there is no EXC state and no epc_write port; illegal instructions behave as NOP, going DECODE→FETCH.

Decomposition:
- Package mc_ctrl_pkg:
  - Opcode and funct constants.
  - AluCtrl codes.
  - npc_sel, reg_dst, wd_sel and ext_op encodings.
  - State enumeration.
- Sub-module mc_ctrl_dec: purely combinational opcode/funct → class, alu_ctrl and ext_op decode, reused by the FSM.

Test Plan:
- addu (op 000000, funct 100001), imem_ready=1 throughout → states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=01; exactly 4 cycles.
- lw (100011) with dmem_ready low for 3 cycles → MEM lasts 4 cycles with mem_read=1 throughout; WB has wd_sel=01 and reg_dst=00; total 8 cycles.
- beq (000100) with zero=0, then zero=1 → EXEC pc_write is 0, then 1 with npc_sel=001; both return to FETCH after 3 cycles.
- jal (000011) → EXEC has pc_write=1, npc_sel=010, reg_write=1, reg_dst=10, wd_sel=10.
- MEM_TIMEOUT=4, sw with dmem_ready held 0 → bus_err pulses on the 5th MEM cycle, mem_write is never accompanied by dmem_ready, next state FETCH.
- opcode 111111 → illegal pulses in DECODE. With MC_CTRL_EXC_EN: EXC with npc_sel=101 and epc_write=1. Without it: straight back to FETCH. Also assert rst mid-MEM → next cycle FETCH with all strobes 0.
